// File: rtl/c7bifu_fetch.sv
// c7bifu_fetch: instruction fetch sequencer of the c7b IFU.
// Owns the fetch PC, issues one 64-bit aligned memory read at a time,
// buffers the response and writes it to the instruction queue when the
// queue can accept it. A flush redirects the PC and drops any in-flight data.
module c7bifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000,
    parameter logic [31:0] NOP_INST = 32'h0340_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    input  logic        iq_full,
    output logic [31:0] data_addr,
    output logic [63:0] data,
    output logic        data_vld
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    logic [2:0]  state_q,    state_d;
    logic [31:2] fetch_pc_q, fetch_pc_d;
    logic [31:3] buf_addr_q, buf_addr_d;
    logic [63:0] buf_data_q, buf_data_d;
    logic        buf_pad_q,  buf_pad_d;
    logic        resp_owed;

    // Redirect targets are word aligned; the byte offset bits carry no meaning.
    logic unused_flush_pc_lsb;
    assign unused_flush_pc_lsb = ^flush_pc[1:0];

    // Outputs decoded from registered state; data_vld also gates on the queue and flush.
    always_comb begin
        mem_req   = (state_q == ST_REQ);
        mem_addr  = {fetch_pc_q[31:3], 3'b000};
        data_addr = {buf_addr_q, 3'b000};
        data      = buf_pad_q ? {buf_data_q[63:32], NOP_INST} : buf_data_q;
        data_vld  = (state_q == ST_HOLD) && !iq_full && !flush;
    end

    // Next-state logic: flush overrides every other event in the same cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        buf_pad_d  = buf_pad_q;
        resp_owed  = ((state_q == ST_WAIT)  && !mem_rvalid) ||
                     ((state_q == ST_REQ)   &&  mem_ack)    ||
                     ((state_q == ST_DRAIN) && !mem_rvalid);

        if (flush) begin
            fetch_pc_d = flush_pc[31:2];
            state_d    = resp_owed ? ST_DRAIN : ST_REQ;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_REQ;
                ST_REQ: begin
                    if (mem_ack) begin
                        buf_pad_d  = fetch_pc_q[2];
                        buf_addr_d = fetch_pc_q[31:3];
                        // 29-bit increment of the aligned block wraps modulo 2^32.
                        fetch_pc_d = {fetch_pc_q[31:3] + 29'd1, 1'b0};
                        state_d    = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        buf_data_d = mem_rdata;
                        state_d    = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (data_vld) state_d = ST_REQ;
                end
                ST_DRAIN: begin
                    if (mem_rvalid) state_d = ST_REQ;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC[31:2];
            buf_addr_q <= '0;
            buf_data_q <= '0;
            buf_pad_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            buf_pad_q  <= buf_pad_d;
        end
    end

endmodule

// File: tb/tb_c7bifu_fetch.sv
// tb_c7bifu_fetch: scripted cycle-by-cycle stimulus with a write scoreboard.
// Expected queue writes are pushed when the response is driven and popped
// by a monitor whenever data_vld is seen.
module tb_c7bifu_fetch;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic [31:0] flush_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        iq_full;
    logic [31:0] data_addr;
    logic [63:0] data;
    logic        data_vld;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    c7bifu_fetch dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .iq_full    (iq_full),
        .data_addr  (data_addr),
        .data       (data),
        .data_vld   (data_vld)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One cycle: inputs applied just after the rising edge, outputs observed at the falling edge.
    task automatic drive(input logic f, input logic [31:0] fpc, input logic ack,
                         input logic rv, input logic [63:0] rd, input logic full);
        @(posedge clk);
        #1;
        flush      = f;
        flush_pc   = fpc;
        mem_ack    = ack;
        mem_rvalid = rv;
        mem_rdata  = rd;
        iq_full    = full;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0);
    endtask

    task automatic push(input logic [31:0] a, input logic [63:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Scoreboard: every queue write must match the oldest expected entry.
    always @(negedge clk) begin
        if (resetn === 1'b1 && data_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'd1, 64'd0);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("wr_addr", {32'h0, data_addr}, {32'h0, w.addr});
                check("wr_data", data, w.data);
            end
        end
    end

    initial begin
        resetn     = 1'b0;
        flush      = 1'b0;
        flush_pc   = 32'h0;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 64'h0;
        iq_full    = 1'b0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_mem_req",   {63'h0, mem_req},   64'd0);
        check("rst_mem_addr",  {32'h0, mem_addr},  64'h1c00_0000);
        check("rst_data_vld",  {63'h0, data_vld},  64'd0);
        check("rst_data_addr", {32'h0, data_addr}, 64'd0);
        check("rst_data",      data,               64'd0);
        @(posedge clk);
        #1 resetn = 1'b1;

        // Basic fetch: ack at once, response next cycle
        drive(1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0);
        check("f1_req",  {63'h0, mem_req},  64'd1);
        check("f1_addr", {32'h0, mem_addr}, 64'h1c00_0000);
        push(32'h1c00_0000, 64'h11111111_22222222);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 64'h11111111_22222222, 1'b0);
        check("f1_wait_vld", {63'h0, data_vld}, 64'd0);
        idle();
        check("f1_hold_vld", {63'h0, data_vld}, 64'd1);
        check("f1_hold_req", {63'h0, mem_req},  64'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0);
        check("f2_req",  {63'h0, mem_req},  64'd1);
        check("f2_addr", {32'h0, mem_addr}, 64'h1c00_0008);
        check("f2_vld",  {63'h0, data_vld}, 64'd0);

        // Queue full for 5 cycles while holding
        push(32'h1c00_0008, 64'h33333333_44444444);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 64'h33333333_44444444, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b1);
            check("full_vld",  {63'h0, data_vld}, 64'd0);
            check("full_req",  {63'h0, mem_req},  64'd0);
            check("full_data", data,              64'h33333333_44444444);
        end
        idle();
        check("full_release_vld", {63'h0, data_vld}, 64'd1);

        // Flush in WAIT, response arrives three cycles later and is dropped
        drive(1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0);
        check("f3_addr", {32'h0, mem_addr}, 64'h1c00_0010);
        drive(1'b1, 32'h8000_0010, 1'b0, 1'b0, 64'h0, 1'b0);
        idle();
        check("drain_req", {63'h0, mem_req}, 64'd0);
        idle();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 64'hDEADBEEF_DEADBEEF, 1'b0);
        check("drain_rv_vld", {63'h0, data_vld}, 64'd0);
        check("drain_rv_req", {63'h0, mem_req},  64'd0);
        idle();
        check("redir_req",  {63'h0, mem_req},  64'd1);
        check("redir_addr", {32'h0, mem_addr}, 64'h8000_0010);
        check("redir_vld",  {63'h0, data_vld}, 64'd0);

        // Flush in REQ without ack to a misaligned target: NOP padding
        drive(1'b1, 32'h8000_0014, 1'b0, 1'b0, 64'h0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0);
        check("pad_req",  {63'h0, mem_req},  64'd1);
        check("pad_addr", {32'h0, mem_addr}, 64'h8000_0010);
        push(32'h8000_0010, 64'hAAAAAAAA_03400000);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 64'hAAAAAAAA_BBBBBBBB, 1'b0);
        idle();
        check("pad_vld",       {63'h0, data_vld},  64'd1);
        check("pad_data_addr", {32'h0, data_addr}, 64'h8000_0010);
        check("pad_data",      data,               64'hAAAAAAAA_03400000);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0);
        check("pad_next_addr", {32'h0, mem_addr}, 64'h8000_0018);

        // Flush coincident with rvalid in WAIT: response dropped
        drive(1'b1, 32'h8000_0100, 1'b0, 1'b1, 64'h55555555_66666666, 1'b0);
        check("fl_rv_vld", {63'h0, data_vld}, 64'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0);
        check("fl_rv_req",  {63'h0, mem_req},  64'd1);
        check("fl_rv_addr", {32'h0, mem_addr}, 64'h8000_0100);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 64'h77777777_88888888, 1'b0);

        // Flush coincident with a would-be write in HOLD: write suppressed
        drive(1'b1, 32'h8000_0200, 1'b0, 1'b0, 64'h0, 1'b0);
        check("fl_hold_vld", {63'h0, data_vld}, 64'd0);
        idle();
        check("fl_hold_req",  {63'h0, mem_req},  64'd1);
        check("fl_hold_addr", {32'h0, mem_addr}, 64'h8000_0200);

        // Wrap of the fetch PC at the top of the address space
        drive(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0, 64'h0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0);
        check("wrap_addr0", {32'h0, mem_addr}, 64'hFFFF_FFF8);
        push(32'hFFFF_FFF8, 64'h99999999_12345678);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 64'h99999999_12345678, 1'b0);
        idle();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0);
        check("wrap_req",   {63'h0, mem_req},  64'd1);
        check("wrap_addr1", {32'h0, mem_addr}, 64'h0000_0000);
        push(32'h0000_0000, 64'hCAFEF00D_0BADBEEF);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 64'hCAFEF00D_0BADBEEF, 1'b0);
        idle();
        check("wrap_vld", {63'h0, data_vld}, 64'd1);
        idle();

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
